// File: rtl/execute_stage.sv
// EX stage of the RV32 pipeline: operand select, single-cycle ALU and the EX/MEM register.
// Define EX_MULDIV_EN to build MUL and the iterative DIV/DIVU/REM/REMU unit; otherwise ops 10-14 yield 0.
package execute_stage_pkg;
    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic [4:0] rd;
    } control_type;
endpackage

module execute_stage
    import execute_stage_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int DIV_CYCLES = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_in,
    input  logic [XLEN-1:0] data1,
    input  logic [XLEN-1:0] data2,
    input  logic [XLEN-1:0] immediate,
    input  logic            alu_src,
    input  logic [3:0]      alu_op,
    input  logic            mem_write_in,
    input  logic            mem_read_in,
    input  control_type     control_in,
    input  logic            flush,
    output logic            stall_out,
    output logic            valid_out,
    output logic [XLEN-1:0] alu_result,
    output logic [XLEN-1:0] mem_wdata,
    output logic            MemWrite,
    output logic            MemRead,
    output control_type     control_out
);

    if (XLEN != 32 || DIV_CYCLES != XLEN) begin : g_bad_cfg
        $error("execute_stage supports only XLEN=32 with DIV_CYCLES=XLEN");
    end

    logic [XLEN-1:0] op_b;
    logic [4:0]      shamt;
    logic [XLEN-1:0] alu_comb;
    logic [XLEN-1:0] ex_result;

    assign op_b  = alu_src ? immediate : data2;
    assign shamt = op_b[4:0];

    always_comb begin
        alu_comb = '0;
        case (alu_op)
            4'd0:  alu_comb = data1 + op_b;
            4'd1:  alu_comb = data1 - op_b;
            4'd2:  alu_comb = data1 & op_b;
            4'd3:  alu_comb = data1 | op_b;
            4'd4:  alu_comb = data1 ^ op_b;
            4'd5:  alu_comb = data1 << shamt;
            4'd6:  alu_comb = data1 >> shamt;
            4'd7:  alu_comb = $signed(data1) >>> shamt;
            4'd8:  alu_comb = {{(XLEN-1){1'b0}}, $signed(data1) < $signed(op_b)};
            4'd9:  alu_comb = {{(XLEN-1){1'b0}}, data1 < op_b};
`ifdef EX_MULDIV_EN
            4'd10: alu_comb = data1 * op_b;
`endif
            4'd15: alu_comb = op_b;
            default: alu_comb = '0;
        endcase
    end

`ifdef EX_MULDIV_EN
    localparam int CW = $clog2(DIV_CYCLES);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

    div_state_t      state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quot_q, quot_d;
    logic [XLEN-1:0] dvsr_q, dvsr_d;
    logic            q_neg_q, q_neg_d;
    logic            r_neg_q, r_neg_d;
    logic            is_rem_q, is_rem_d;
    logic            stall_div;

    logic            is_div_op, signed_op, a_neg, b_neg, div_start;
    logic [XLEN-1:0] abs_a, abs_b;
    logic [XLEN:0]   rem_shift, diff;
    logic [XLEN-1:0] quot_fix, rem_fix, div_result;

    assign is_div_op = (alu_op >= 4'd11) && (alu_op <= 4'd14);
    assign signed_op = (alu_op == 4'd11) || (alu_op == 4'd13);
    assign a_neg     = signed_op & data1[XLEN-1];
    assign b_neg     = signed_op & op_b[XLEN-1];
    assign abs_a     = a_neg ? -data1 : data1;
    assign abs_b     = b_neg ? -op_b : op_b;
    assign div_start = valid_in && is_div_op && !flush;

    // Restoring step: a borrow out of diff means the trial subtraction failed.
    assign rem_shift = {rem_q, quot_q[XLEN-1]};
    assign diff      = rem_shift - {1'b0, dvsr_q};

    // Divide-by-zero leaves the quotient all ones, so its sign is never flipped.
    assign quot_fix   = q_neg_q ? -quot_q : quot_q;
    assign rem_fix    = r_neg_q ? -rem_q : rem_q;
    assign div_result = is_rem_q ? rem_fix : quot_fix;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        rem_d     = rem_q;
        quot_d    = quot_q;
        dvsr_d    = dvsr_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        is_rem_d  = is_rem_q;
        stall_div = 1'b0;
        case (state_q)
            IDLE: begin
                if (div_start) begin
                    stall_div = 1'b1;
                    state_d   = BUSY;
                    count_d   = '0;
                    rem_d     = '0;
                    quot_d    = abs_a;
                    dvsr_d    = abs_b;
                    q_neg_d   = (a_neg ^ b_neg) && (op_b != '0);
                    r_neg_d   = a_neg;
                    is_rem_d  = (alu_op == 4'd13) || (alu_op == 4'd14);
                end
            end
            BUSY: begin
                stall_div = 1'b1;
                if (!diff[XLEN]) begin
                    rem_d  = diff[XLEN-1:0];
                    quot_d = {quot_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_d  = rem_shift[XLEN-1:0];
                    quot_d = {quot_q[XLEN-2:0], 1'b0};
                end
                if (count_q == CW'(DIV_CYCLES-1)) begin
                    state_d = DONE;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                count_d = '0;
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d   = IDLE;
            count_d   = '0;
            stall_div = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            rem_q    <= '0;
            quot_q   <= '0;
            dvsr_q   <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            is_rem_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rem_q    <= rem_d;
            quot_q   <= quot_d;
            dvsr_q   <= dvsr_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            is_rem_q <= is_rem_d;
        end
    end

    assign stall_out = stall_div;
    assign ex_result = (state_q == DONE) ? div_result : alu_comb;
`else
    assign stall_out = 1'b0;
    assign ex_result = alu_comb;
`endif

    logic            valid_q, valid_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic            mem_write_q, mem_write_d;
    logic            mem_read_q, mem_read_d;
    control_type     control_q, control_d;

    // Bubbles clear the qualifying flags but leave the data fields untouched.
    always_comb begin
        valid_d     = 1'b0;
        mem_write_d = 1'b0;
        mem_read_d  = 1'b0;
        control_d   = '0;
        result_d    = result_q;
        wdata_d     = wdata_q;
        if (!flush && !stall_out && valid_in) begin
            valid_d     = 1'b1;
            mem_write_d = mem_write_in;
            mem_read_d  = mem_read_in;
            control_d   = control_in;
            result_d    = ex_result;
            wdata_d     = data2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= 1'b0;
            result_q    <= '0;
            wdata_q     <= '0;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            control_q   <= '0;
        end else begin
            valid_q     <= valid_d;
            result_q    <= result_d;
            wdata_q     <= wdata_d;
            mem_write_q <= mem_write_d;
            mem_read_q  <= mem_read_d;
            control_q   <= control_d;
        end
    end

    assign valid_out   = valid_q;
    assign alu_result  = result_q;
    assign mem_wdata   = wdata_q;
    assign MemWrite    = mem_write_q;
    assign MemRead     = mem_read_q;
    assign control_out = control_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage; division checks adapt to whether EX_MULDIV_EN is defined.
module tb_execute_stage;
    import execute_stage_pkg::*;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic [31:0] data1, data2, immediate;
    logic        alu_src;
    logic [3:0]  alu_op;
    logic        mem_write_in, mem_read_in;
    control_type control_in;
    logic        flush;
    logic        stall_out, valid_out;
    logic [31:0] alu_result, mem_wdata;
    logic        MemWrite, MemRead;
    control_type control_out;

    int checks   = 0;
    int failures = 0;

    execute_stage dut (
        .clk          (clk),
        .rst          (rst),
        .valid_in     (valid_in),
        .data1        (data1),
        .data2        (data2),
        .immediate    (immediate),
        .alu_src      (alu_src),
        .alu_op       (alu_op),
        .mem_write_in (mem_write_in),
        .mem_read_in  (mem_read_in),
        .control_in   (control_in),
        .flush        (flush),
        .stall_out    (stall_out),
        .valid_out    (valid_out),
        .alu_result   (alu_result),
        .mem_wdata    (mem_wdata),
        .MemWrite     (MemWrite),
        .MemRead      (MemRead),
        .control_out  (control_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic src, input logic mw, input logic mr,
                         input control_type ctl);
        valid_in     = 1'b1;
        alu_op       = op;
        data1        = a;
        data2        = b;
        immediate    = imm;
        alu_src      = src;
        mem_write_in = mw;
        mem_read_in  = mr;
        control_in   = ctl;
    endtask

    task automatic idle_in();
        valid_in     = 1'b0;
        mem_write_in = 1'b0;
        mem_read_in  = 1'b0;
        control_in   = '0;
    endtask

    // Issues one div-class op and checks stall length, bubbles and the final value.
    task automatic run_div(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_v);
        int stall_cnt;
        int leak;
        control_type ctl;
        ctl = '{reg_write: 1'b1, mem_to_reg: 1'b0, rd: 5'd9};
        issue(op, a, b, 32'h0, 1'b0, 1'b1, 1'b0, ctl);
        #1;
`ifdef EX_MULDIV_EN
        stall_cnt = 0;
        leak      = 0;
        while (stall_out && stall_cnt < 100) begin
            stall_cnt++;
            step();
            if (valid_out || MemWrite) leak++;
        end
        chk({tag, "_stall_cycles"}, 32'(stall_cnt), 32'd33);
        chk({tag, "_bubble_leaks"}, 32'(leak), 32'd0);
`else
        chk({tag, "_no_stall"}, {31'b0, stall_out}, 32'd0);
`endif
        step();
        idle_in();
        chk({tag, "_result"}, alu_result, exp_v);
        chk({tag, "_valid"}, {31'b0, valid_out}, 32'd1);
    endtask

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic        src;
        logic [31:0] exp_v;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    control_type c1;
    logic [31:0] expected_div;

    initial begin
        c1 = '{reg_write: 1'b1, mem_to_reg: 1'b1, rd: 5'd7};
        vecs[0]  = '{"sub",      4'd1,  32'd3,        32'd5,        32'h0,        1'b0, 32'hFFFF_FFFE};
        vecs[1]  = '{"and",      4'd2,  32'hF0F0_FF00, 32'h0FF0_F0F0, 32'h0,      1'b0, 32'h00F0_F000};
        vecs[2]  = '{"or",       4'd3,  32'hF000_0001, 32'h0000_0F00, 32'h0,      1'b0, 32'hF000_0F01};
        vecs[3]  = '{"xor",      4'd4,  32'hAAAA_5555, 32'hFFFF_0000, 32'h0,      1'b0, 32'h5555_5555};
        vecs[4]  = '{"sll_mask", 4'd5,  32'd1,        32'h0000_003F, 32'h0,       1'b0, 32'h8000_0000};
        vecs[5]  = '{"srl",      4'd6,  32'h8000_0000, 32'd4,       32'h0,        1'b0, 32'h0800_0000};
        vecs[6]  = '{"sra",      4'd7,  32'h8000_0000, 32'd4,       32'h0,        1'b0, 32'hF800_0000};
        vecs[7]  = '{"slt",      4'd8,  32'hFFFF_FFFF, 32'd1,       32'h0,        1'b0, 32'd1};
        vecs[8]  = '{"slt_neg",  4'd8,  32'd1,        32'hFFFF_FFFF, 32'h0,       1'b0, 32'd0};
        vecs[9]  = '{"sltu",     4'd9,  32'd1,        32'hFFFF_FFFF, 32'h0,       1'b0, 32'd1};
        vecs[10] = '{"sltu_rev", 4'd9,  32'hFFFF_FFFF, 32'd1,       32'h0,        1'b0, 32'd0};
        vecs[11] = '{"passb",    4'd15, 32'hDEAD_BEEF, 32'd0,       32'h1234_5000, 1'b1, 32'h1234_5000};
        vecs[12] = '{"addi_imm", 4'd0,  32'd100,      32'd7,        32'hFFFF_FF9C, 1'b1, 32'd0};
        vecs[13] = '{"sub_wrap", 4'd1,  32'h0,        32'd1,        32'h0,        1'b0, 32'hFFFF_FFFF};
`ifdef EX_MULDIV_EN
        vecs[14] = '{"mul",      4'd10, 32'd7,        32'hFFFF_FFFD, 32'h0,       1'b0, 32'hFFFF_FFEB};
`else
        vecs[14] = '{"mul_off",  4'd10, 32'd7,        32'hFFFF_FFFD, 32'h0,       1'b0, 32'h0};
`endif

        rst   = 1'b1;
        flush = 1'b0;
        data1 = '0; data2 = '0; immediate = '0; alu_src = 1'b0; alu_op = '0;
        idle_in();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'b0, valid_out}, 32'd0);
        chk("rst_result", alu_result, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_memwrite", {31'b0, MemWrite}, 32'd0);
        chk("rst_memread", {31'b0, MemRead}, 32'd0);
        chk("rst_control", {25'b0, control_out}, 32'd0);
        chk("rst_stall", {31'b0, stall_out}, 32'd0);
        rst = 1'b0;
        step();

        // ADD with immediate -1 and full control propagation
        issue(4'd0, 32'd5, 32'h0000_0100, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, c1);
        step();
        chk("add_imm_result", alu_result, 32'd4);
        chk("add_imm_valid", {31'b0, valid_out}, 32'd1);
        chk("add_imm_control", {25'b0, control_out}, {25'b0, c1});
        chk("add_imm_wdata", mem_wdata, 32'h0000_0100);

        // Back-to-back single-cycle ops, latency 1 each
        for (int i = 0; i < NV; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].src, 1'b0, 1'b0, c1);
            step();
            chk(vecs[i].name, alu_result, vecs[i].exp_v);
        end

        // Store flag visible for exactly one cycle; data held across the bubble
        issue(4'd0, 32'h10, 32'hCAFE_BABE, 32'h0, 1'b1, 1'b1, 1'b0, c1);
        step();
        idle_in();
        chk("store_memwrite", {31'b0, MemWrite}, 32'd1);
        chk("store_wdata", mem_wdata, 32'hCAFE_BABE);
        chk("store_memread", {31'b0, MemRead}, 32'd0);
        step();
        chk("bubble_memwrite", {31'b0, MemWrite}, 32'd0);
        chk("bubble_valid", {31'b0, valid_out}, 32'd0);
        chk("bubble_control", {25'b0, control_out}, 32'd0);
        chk("bubble_wdata_hold", mem_wdata, 32'hCAFE_BABE);
        chk("bubble_result_hold", alu_result, 32'h10);

        issue(4'd0, 32'h20, 32'h0, 32'h4, 1'b1, 1'b0, 1'b1, c1);
        step();
        idle_in();
        chk("load_memread", {31'b0, MemRead}, 32'd1);
        chk("load_addr", alu_result, 32'h24);

        // Division cases (zero-result with latency 1 when the unit is not built)
`ifdef EX_MULDIV_EN
        expected_div = 32'hFFFF_FFFD;
`else
        expected_div = 32'h0;
`endif
        run_div("div_neg7_2", 4'd11, 32'hFFFF_FFF9, 32'd2, expected_div);
`ifdef EX_MULDIV_EN
        run_div("rem_neg7_2", 4'd13, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_div("remu_by0", 4'd14, 32'h0000_1234, 32'd0, 32'h0000_1234);
        run_div("divu_by0", 4'd12, 32'd100, 32'd0, 32'hFFFF_FFFF);
        run_div("div_neg_by0", 4'd11, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF);
        run_div("div_ovf", 4'd11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_div("rem_ovf", 4'd13, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
        run_div("divu_big", 4'd12, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555);
`else
        run_div("remu_by0", 4'd14, 32'h0000_1234, 32'd0, 32'h0);
`endif

        // Flush of a plain ALU op: bubble, data held
        issue(4'd0, 32'd1, 32'd1, 32'h0, 1'b0, 1'b1, 1'b0, c1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle_in();
        chk("flush_alu_valid", {31'b0, valid_out}, 32'd0);
        chk("flush_alu_memwrite", {31'b0, MemWrite}, 32'd0);
        chk("flush_alu_hold", alu_result, expected_div == 32'h0 ? 32'h0 : 32'h5555_5555);

`ifdef EX_MULDIV_EN
        // Flush in BUSY cycle 10, then a fresh division must take the full time
        issue(4'd11, 32'd50, 32'd5, 32'h0, 1'b0, 1'b0, 1'b0, c1);
        repeat (10) step();
        chk("flush_pre_stall", {31'b0, stall_out}, 32'd1);
        flush = 1'b1;
        idle_in();
        #1;
        chk("flush_stall_drop", {31'b0, stall_out}, 32'd0);
        step();
        flush = 1'b0;
        #1;
        chk("flush_next_stall", {31'b0, stall_out}, 32'd0);
        chk("flush_next_valid", {31'b0, valid_out}, 32'd0);
        run_div("div_after_flush", 4'd12, 32'd20, 32'd3, 32'd6);
`endif

        // Asynchronous reset away from the clock edge
        issue(4'd0, 32'd9, 32'd1, 32'h0, 1'b0, 1'b1, 1'b1, c1);
        step();
        idle_in();
        chk("pre_rst_result", alu_result, 32'd10);
`ifdef EX_MULDIV_EN
        issue(4'd11, 32'd77, 32'd7, 32'h0, 1'b0, 1'b0, 1'b0, c1);
        repeat (5) step();
`endif
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_result", alu_result, 32'd0);
        chk("async_rst_valid", {31'b0, valid_out}, 32'd0);
        chk("async_rst_memwrite", {31'b0, MemWrite}, 32'd0);
        chk("async_rst_memread", {31'b0, MemRead}, 32'd0);
        chk("async_rst_wdata", mem_wdata, 32'd0);
        idle_in();
        #1;
        rst = 1'b0;
        step();

        // After reset the pipeline resumes normally
        issue(4'd1, 32'd10, 32'd4, 32'h0, 1'b0, 1'b0, 1'b0, c1);
        #1;
        chk("post_rst_stall", {31'b0, stall_out}, 32'd0);
        step();
        idle_in();
        chk("post_rst_result", alu_result, 32'd6);
        run_div("post_rst_div", 4'd11, 32'hFFFF_FFF9, 32'd2, expected_div);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
